// File: rtl/i2c_cfg_seq.sv
// rtl/i2c_cfg_seq.sv - walks the I2C config ROM and replays each entry as a bus write or timed wait
// Define I2C_CFG_RETRY_EN to re-issue a NACKed write up to three times before flagging an error.
module i2c_cfg_seq #(
  parameter int LINES    = 16,
  parameter int DW       = 32,
  parameter int QTR_DIV  = 250,
  parameter int DLY_UNIT = 100000,
  localparam int AW      = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW-1:0] rom_data_i,
  output logic          scl_low_o,
  output logic          sda_low_o,
  input  logic          sda_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int DIVW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH, FWAIT, DECODE, START, BIT, ACK, STOP, DELAY, DONE, ERR, RWAIT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [1:0]      byte_q, byte_d;
  logic            nack_q, nack_d;
  logic [31:0]     entry_q, entry_d;
  logic [31:0]     dly_q, dly_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;
`ifdef I2C_CFG_RETRY_EN
  logic [1:0]      retry_q, retry_d;
`endif

  logic       tick;
  logic       go_next;
  logic       begin_xfer;
  logic [7:0] cur_byte;
  logic       cur_bit;

  // Line drive per state/quarter, returned as {scl_low, sda_low}.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q, input logic bitv);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      START:   d = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b01 : 2'b11;
      BIT:     d = {(q == 2'd0) || (q == 2'd3), ~bitv};
      ACK:     d = {(q == 2'd0) || (q == 2'd3), 1'b0};
      STOP:    d = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bitcnt_d   = bitcnt_q;
    byte_d     = byte_q;
    nack_d     = nack_q;
    entry_d    = entry_q;
    dly_d      = dly_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef I2C_CFG_RETRY_EN
    retry_d    = retry_q;
`endif
    go_next    = 1'b0;
    begin_xfer = 1'b0;
    cur_byte   = 8'h00;
    cur_bit    = 1'b0;
    tick       = (div_q == DIVW'(QTR_DIV - 1));

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = FETCH;
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef I2C_CFG_RETRY_EN
          retry_d = 2'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = FWAIT;
      FWAIT: begin
        entry_d = rom_data_i[31:0];
        state_d = DECODE;
      end
      DECODE: begin
        case (entry_q[7:0])
          8'h00: begin_xfer = 1'b1;
          8'h01: begin
            if (entry_q[15:8] == 8'd0) begin
              go_next = 1'b1;
            end else begin
              dly_d   = 32'(entry_q[15:8]) * 32'(DLY_UNIT);
              state_d = DELAY;
            end
          end
          8'hFF:   state_d = DONE;
          default: go_next = 1'b1;
        endcase
      end
      START: if (tick && qtr_q == 2'd2) state_d = BIT;
      BIT: begin
        if (tick && qtr_q == 2'd3) begin
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = 3'd0;
            state_d  = ACK;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      ACK: begin
        if (tick && qtr_q == 2'd2) nack_d = sda_i;
        if (tick && qtr_q == 2'd3) begin
          if (nack_q || byte_q == 2'd2) begin
            state_d = STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = BIT;
          end
        end
      end
      STOP: begin
        if (tick && qtr_q == 2'd2) begin
          if (!nack_q) begin
            go_next = 1'b1;
`ifdef I2C_CFG_RETRY_EN
          end else if (retry_q != 2'd3) begin
            retry_d = retry_q + 2'd1;
            state_d = RWAIT;
`endif
          end else begin
            state_d = ERR;
          end
        end
      end
`ifdef I2C_CFG_RETRY_EN
      RWAIT: if (tick && qtr_q == 2'd3) begin_xfer = 1'b1;
`endif
      DELAY: begin
        if (dly_q <= 32'd1) go_next = 1'b1;
        else dly_d = dly_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (begin_xfer) begin
      state_d  = START;
      byte_d   = 2'd0;
      bitcnt_d = 3'd0;
      nack_d   = 1'b0;
    end

    // A table without an end marker stops at the last line instead of wrapping.
    if (go_next) begin
`ifdef I2C_CFG_RETRY_EN
      retry_d = 2'd0;
`endif
      if (addr_q == AW'(LINES - 1)) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = FETCH;
      end
    end

    if (state_d != state_q) begin
      div_d = '0;
      qtr_d = 2'd0;
    end else if (tick) begin
      div_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (state_d == DONE) done_d = 1'b1;
    if (state_d == ERR)  err_d  = 1'b1;
    busy_d = !(state_d inside {IDLE, DONE, ERR});

    case (byte_d)
      2'd0:    cur_byte = entry_q[31:24];
      2'd1:    cur_byte = entry_q[23:16];
      default: cur_byte = entry_q[15:8];
    endcase
    cur_bit = cur_byte[3'd7 - bitcnt_d];
    // Pad drives are registered from next-state so they line up with state_q glitch-free.
    {scl_d, sda_d} = bus_drive(state_d, qtr_d, cur_bit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      div_q    <= '0;
      qtr_q    <= 2'd0;
      bitcnt_q <= 3'd0;
      byte_q   <= 2'd0;
      nack_q   <= 1'b0;
      entry_q  <= 32'd0;
      dly_q    <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
      retry_q  <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bitcnt_q <= bitcnt_d;
      byte_q   <= byte_d;
      nack_q   <= nack_d;
      entry_q  <= entry_d;
      dly_q    <= dly_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
`ifdef I2C_CFG_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign rom_addr_o = addr_q;
  assign scl_low_o  = scl_q;
  assign sda_low_o  = sda_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
